// File: rtl/led_seg_io.sv
// LED latch and 8-digit multiplexed seven-segment driver behind a small IO write port.
// Decimal points are built only when SEG_DP_EN is defined; otherwise seg_out[7] stays high.
module led_seg_io #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        led_cs,
  input  logic        io_write,
  input  logic [3:0]  io_addr,
  input  logic [31:0] io_wdata,
  output logic [23:0] led,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out,
  output logic        wr_ack
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(SCAN_DIV - 1);

  logic [31:0]   seg_data;
  logic [7:0]    blank_mask;
  logic [PW-1:0] prescaler;
  logic [2:0]    idx;
  logic          wr_en;
  logic [7:0]    seg_an_nxt;
  logic [7:0]    seg_out_nxt;
  logic [3:0]    nibble;
  logic          dp_bit;

`ifdef SEG_DP_EN
  logic [7:0]    dp_mask;
`endif

  always_comb begin
    wr_en = 1'b0;
    if (led_cs && io_write) begin
      case (io_addr)
        4'h0, 4'h2, 4'h4, 4'h8: wr_en = 1'b1;
        default:                wr_en = 1'b0;
      endcase
    end
  end

  always_comb begin
    nibble     = seg_data[{idx, 2'b00} +: 4];
    seg_an_nxt = blank_mask[idx] ? 8'hFF : ~(8'h01 << idx);
`ifdef SEG_DP_EN
    dp_bit     = ~dp_mask[idx];
`else
    dp_bit     = 1'b1;
`endif
    // Active-low segments {g,f,e,d,c,b,a}
    case (nibble)
      4'h0:    seg_out_nxt = {dp_bit, 7'h40};
      4'h1:    seg_out_nxt = {dp_bit, 7'h79};
      4'h2:    seg_out_nxt = {dp_bit, 7'h24};
      4'h3:    seg_out_nxt = {dp_bit, 7'h30};
      4'h4:    seg_out_nxt = {dp_bit, 7'h19};
      4'h5:    seg_out_nxt = {dp_bit, 7'h12};
      4'h6:    seg_out_nxt = {dp_bit, 7'h02};
      4'h7:    seg_out_nxt = {dp_bit, 7'h78};
      4'h8:    seg_out_nxt = {dp_bit, 7'h00};
      4'h9:    seg_out_nxt = {dp_bit, 7'h10};
      4'hA:    seg_out_nxt = {dp_bit, 7'h08};
      4'hB:    seg_out_nxt = {dp_bit, 7'h03};
      4'hC:    seg_out_nxt = {dp_bit, 7'h46};
      4'hD:    seg_out_nxt = {dp_bit, 7'h21};
      4'hE:    seg_out_nxt = {dp_bit, 7'h06};
      default: seg_out_nxt = {dp_bit, 7'h0E};
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      led        <= '0;
      seg_data   <= '0;
      blank_mask <= 8'hFF;
`ifdef SEG_DP_EN
      dp_mask    <= '0;
`endif
      wr_ack     <= 1'b0;
    end else begin
      wr_ack <= wr_en;
      if (wr_en) begin
        case (io_addr)
          4'h0: led[15:0]  <= io_wdata[15:0];
          4'h2: led[23:16] <= io_wdata[7:0];
          4'h4: seg_data   <= io_wdata;
          4'h8: begin
            blank_mask <= io_wdata[7:0];
`ifdef SEG_DP_EN
            dp_mask    <= io_wdata[15:8];
`endif
          end
          default: ;
        endcase
      end
    end
  end

  // Scan timing runs independently of the write port.
  always_ff @(posedge clock) begin
    if (!reset) begin
      prescaler <= '0;
      idx       <= '0;
      seg_an    <= 8'hFF;
      seg_out   <= 8'hFF;
    end else begin
      if (prescaler == PRESCALE_LAST) begin
        prescaler <= '0;
        idx       <= idx + 3'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      seg_an  <= seg_an_nxt;
      seg_out <= seg_out_nxt;
    end
  end

endmodule

// File: tb/tb_led_seg_io.sv
// Directed bench for led_seg_io with a short scan period.
module tb_led_seg_io;

  logic        clock = 1'b0;
  logic        reset;
  logic        led_cs;
  logic        io_write;
  logic [3:0]  io_addr;
  logic [31:0] io_wdata;
  logic [23:0] led;
  logic [7:0]  seg_an;
  logic [7:0]  seg_out;
  logic        wr_ack;

  int tests = 0;
  int fails = 0;

  led_seg_io #(.SCAN_DIV(4)) dut (
    .clock(clock), .reset(reset), .led_cs(led_cs), .io_write(io_write),
    .io_addr(io_addr), .io_wdata(io_wdata), .led(led), .seg_an(seg_an),
    .seg_out(seg_out), .wr_ack(wr_ack)
  );

  always #5 clock = ~clock;

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic cs);
    led_cs = cs; io_write = 1'b1; io_addr = a; io_wdata = d;
    @(negedge clock);
    led_cs = 1'b0; io_write = 1'b0; io_addr = 4'h0; io_wdata = 32'h0;
  endtask

  // Leaves the bench at the first negedge where digit 0 is freshly shown.
  task automatic sync_digit0(input logic [7:0] last_an);
    for (int i = 0; i < 200 && seg_an !== last_an; i++) @(negedge clock);
    tests++;
    if (seg_an !== last_an) begin
      fails++; $display("FAIL sync_last seg_an=%h required=%h", seg_an, last_an);
    end
    for (int i = 0; i < 20 && seg_an === last_an; i++) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0; led_cs = 1'b0; io_write = 1'b0; io_addr = 4'h0; io_wdata = 32'h0;
    repeat (3) @(negedge clock);
    tests++; if (led !== 24'h0) begin fails++; $display("FAIL rst_led got=%h req=0", led); end
    tests++; if (seg_an !== 8'hFF) begin fails++; $display("FAIL rst_an got=%h req=FF", seg_an); end
    tests++; if (seg_out !== 8'hFF) begin fails++; $display("FAIL rst_seg got=%h req=FF", seg_out); end
    tests++; if (wr_ack !== 1'b0) begin fails++; $display("FAIL rst_ack got=%b req=0", wr_ack); end
    reset = 1'b1;
    @(negedge clock);
    tests++; if (seg_out !== 8'hC0) begin fails++; $display("FAIL rel_seg got=%h req=C0", seg_out); end
    tests++; if (seg_an !== 8'hFF) begin fails++; $display("FAIL rel_an got=%h req=FF", seg_an); end
  endtask

  task automatic test_led_back_to_back();
    do_write(4'h0, 32'hFFFF_5A5A, 1'b1);
    tests++; if (wr_ack !== 1'b1) begin fails++; $display("FAIL b2b_ack1 got=%b req=1", wr_ack); end
    do_write(4'h2, 32'h0000_00C3, 1'b1);
    tests++; if (wr_ack !== 1'b1) begin fails++; $display("FAIL b2b_ack2 got=%b req=1", wr_ack); end
    tests++; if (led !== 24'hC35A5A) begin fails++; $display("FAIL b2b_led got=%h req=C35A5A", led); end
    @(negedge clock);
    tests++; if (wr_ack !== 1'b0) begin fails++; $display("FAIL b2b_ack_end got=%b req=0", wr_ack); end
  endtask

  task automatic test_ignored_writes();
    do_write(4'h6, 32'hFFFF_FFFF, 1'b1);
    tests++; if (wr_ack !== 1'b0) begin fails++; $display("FAIL unmapped_ack got=%b req=0", wr_ack); end
    tests++; if (led !== 24'hC35A5A) begin fails++; $display("FAIL unmapped_led got=%h req=C35A5A", led); end
    do_write(4'h0, 32'h0000_1111, 1'b0);
    tests++; if (wr_ack !== 1'b0) begin fails++; $display("FAIL nocs_ack got=%b req=0", wr_ack); end
    tests++; if (led !== 24'hC35A5A) begin fails++; $display("FAIL nocs_led got=%h req=C35A5A", led); end
  endtask

  task automatic test_scan();
    logic [6:0] segs [8];
    segs = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
    do_write(4'h8, 32'h0000_0000, 1'b1);
    do_write(4'h4, 32'h1234_ABCD, 1'b1);
    sync_digit0(8'h7F);
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < 4; c++) begin
        tests++;
        if (seg_an !== ~(8'h01 << d) || seg_out[6:0] !== segs[d]) begin
          fails++;
          $display("FAIL scan d%0d c%0d an=%h seg=%h req an=%h seg=%h",
                   d, c, seg_an, seg_out[6:0], ~(8'h01 << d), segs[d]);
        end
        @(negedge clock);
      end
    end
  endtask

  task automatic test_blank();
    logic [7:0] exp_an;
    do_write(4'h8, 32'h0000_000F, 1'b1);
    sync_digit0(8'h7F);
    for (int d = 0; d < 8; d++) begin
      exp_an = (d < 4) ? 8'hFF : ~(8'h01 << d);
      for (int c = 0; c < 4; c++) begin
        tests++;
        if (seg_an !== exp_an) begin
          fails++; $display("FAIL blank d%0d c%0d an=%h req=%h", d, c, seg_an, exp_an);
        end
        @(negedge clock);
      end
    end
  endtask

  task automatic test_dp();
    logic exp_dp;
    do_write(4'h8, 32'h0000_0100, 1'b1);
    sync_digit0(8'h7F);
    for (int d = 0; d < 8; d++) begin
`ifdef SEG_DP_EN
      exp_dp = (d == 0) ? 1'b0 : 1'b1;
`else
      exp_dp = 1'b1;
`endif
      for (int c = 0; c < 4; c++) begin
        tests++;
        if (seg_out[7] !== exp_dp) begin
          fails++; $display("FAIL dp d%0d c%0d dp=%b req=%b", d, c, seg_out[7], exp_dp);
        end
        @(negedge clock);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    do_write(4'h8, 32'h0000_0000, 1'b1);
    for (int i = 0; i < 200 && seg_an !== 8'hDF; i++) @(negedge clock);
    tests++; if (seg_an !== 8'hDF) begin fails++; $display("FAIL mid_sync an=%h req=DF", seg_an); end
    reset = 1'b0; led_cs = 1'b1; io_write = 1'b1; io_addr = 4'h0; io_wdata = 32'h0000_FFFF;
    @(negedge clock);
    led_cs = 1'b0; io_write = 1'b0;
    tests++; if (led !== 24'h0) begin fails++; $display("FAIL mid_led got=%h req=0", led); end
    tests++; if (seg_an !== 8'hFF) begin fails++; $display("FAIL mid_an got=%h req=FF", seg_an); end
    tests++; if (wr_ack !== 1'b0) begin fails++; $display("FAIL mid_ack got=%b req=0", wr_ack); end
    reset = 1'b1;
    do_write(4'h8, 32'h0000_0000, 1'b1);
    tests++; if (wr_ack !== 1'b1) begin fails++; $display("FAIL rel_wr_ack got=%b req=1", wr_ack); end
    tests++; if (seg_an !== 8'hFF) begin fails++; $display("FAIL rel_an0 got=%h req=FF", seg_an); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      tests++;
      if (seg_an !== 8'hFE) begin fails++; $display("FAIL restart c%0d an=%h req=FE", c, seg_an); end
    end
    @(negedge clock);
    tests++; if (seg_an !== 8'hFD) begin fails++; $display("FAIL restart_next an=%h req=FD", seg_an); end
  endtask

  initial begin
    test_reset();
    test_led_back_to_back();
    test_ignored_writes();
    test_scan();
    test_blank();
    test_dp();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
